// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM host controller: command codes,
// frame length, FSM state encoding and the frame-building helper.
// No ports; imported by the controller, its shifter and the bus interface users.
package spi_ram_pkg;

    localparam int FRAME_BITS = 11;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP,
        ST_WAIT,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    // Frame is MSB first: the command MSB is sent twice, then cmd[0], then payload.
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [1:0] cmd,
                                                         input logic [7:0] payload);
        return {cmd[1], cmd[1], cmd[0], payload};
    endfunction

endpackage

// File: rtl/spi_ram_if.sv
// Bundle of the host request/response handshake and the three SPI pins.
// master modport: controller view (takes req/we/addr/wdata/miso, drives ready/done/rdata/ss_n/mosi).
// slave modport: host + RAM side view, directions mirrored.
interface spi_ram_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              ss_n;
    logic              mosi;
    logic              miso;

    modport master (
        input  req, we, addr, wdata, miso,
        output ready, done, rdata, ss_n, mosi
    );

    modport slave (
        output req, we, addr, wdata, miso,
        input  ready, done, rdata, ss_n, mosi
    );
endinterface

// File: rtl/spi_frame_shifter.sv
// Parallel-load MSB-first serializer for one 11-bit SPI frame with a bit counter.
// Ports: clk, rst, load + frame in; sdo (registered serial out), busy, last (counter at 0).
// sdo reads 0 whenever no frame is in flight: eleven left shifts empty the register.
module spi_frame_shifter
    import spi_ram_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [FRAME_BITS-1:0] frame,
    output logic                  sdo,
    output logic                  busy,
    output logic                  last
);

    logic [FRAME_BITS-1:0] sreg_q;
    logic [3:0]            cnt_q;
    logic                  busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (load) begin
            sreg_q <= frame;
            cnt_q  <= 4'(FRAME_BITS - 1);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            sreg_q <= {sreg_q[FRAME_BITS-2:0], 1'b0};
            if (cnt_q == 4'd0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    assign sdo  = sreg_q[FRAME_BITS-1];
    assign busy = busy_q;
    assign last = (cnt_q == 4'd0);

endmodule

// File: rtl/spi_ram_master.sv
// Host-side SPI RAM controller: turns one read/write request into address + data frames,
// samples miso for reads. Latency accept->done: write 23+GAP_CYC, read 31+GAP_CYC+MISO_DLY.
// Backpressure: ready low while a transaction is in flight; req is ignored until ready.
// Ports: clk, rst (sync, active-high), bus (spi_ram_if.master: host handshake + ss_n/mosi/miso).
// Optional macro SPI_ADDR_CACHE_EN: remembers last write/read address and skips the address
// frame + gap when a request repeats the cached address of its direction.
module spi_ram_master
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MISO_DLY = 2,
    parameter int GAP_CYC  = 1
) (
    input  logic     clk,
    input  logic     rst,
    spi_ram_if.master bus
);

    state_t                state_q, state_d;
    logic                  phase_q, phase_d;   // 0: address frame, 1: data frame
    logic [7:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     rsh_q, rsh_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  ss_n_q, ss_n_d;

    logic                  ready;
    logic                  accept;
    logic                  hit;
    logic                  load;
    logic [FRAME_BITS-1:0] frame;
    logic                  sh_sdo, sh_busy, sh_last;

    assign ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign accept = ready && bus.req;

`ifdef SPI_ADDR_CACHE_EN
    logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
    logic              wr_vld_q, rd_vld_q;

    assign hit = bus.we ? (wr_vld_q && (wr_addr_q == bus.addr))
                        : (rd_vld_q && (rd_addr_q == bus.addr));

    // Read and write address registers in the slave are independent, so each
    // direction keeps its own entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            wr_vld_q  <= 1'b0;
            rd_vld_q  <= 1'b0;
        end else if (accept) begin
            if (bus.we) begin
                wr_addr_q <= bus.addr;
                wr_vld_q  <= 1'b1;
            end else begin
                rd_addr_q <= bus.addr;
                rd_vld_q  <= 1'b1;
            end
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rsh_d   = rsh_q;
        rdata_d = rdata_q;
        load    = 1'b0;
        frame   = '0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    we_d    = bus.we;
                    wdata_d = bus.wdata;
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                    if (hit) begin
                        phase_d = 1'b1;
                        frame   = bus.we ? make_frame(CMD_WR_DATA, 8'(bus.wdata))
                                         : make_frame(CMD_RD_DATA, 8'h00);
                    end else begin
                        phase_d = 1'b0;
                        frame   = make_frame(bus.we ? CMD_WR_ADDR : CMD_RD_ADDR, 8'(bus.addr));
                    end
                end
            end
            ST_SHIFT: begin
                if (sh_busy && sh_last) begin
                    if (!phase_q) begin
                        state_d = ST_GAP;
                        cnt_d   = 8'(GAP_CYC - 1);
                    end else if (we_q) begin
                        state_d = ST_DONE;
                    end else if (MISO_DLY == 0) begin
                        state_d = ST_CAPTURE;
                        cnt_d   = 8'(DATA_W - 1);
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 8'(MISO_DLY - 1);
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == 8'd0) begin
                    load    = 1'b1;
                    phase_d = 1'b1;
                    frame   = we_q ? make_frame(CMD_WR_DATA, 8'(wdata_q))
                                   : make_frame(CMD_RD_DATA, 8'h00);
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_CAPTURE;
                    cnt_d   = 8'(DATA_W - 1);
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_CAPTURE: begin
                rsh_d = {rsh_q[DATA_W-2:0], bus.miso};
                if (cnt_q == 8'd0) begin
                    rdata_d = rsh_d;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // ss_n is registered from the next state so it tracks the frame bits exactly.
        ss_n_d = !((state_d == ST_SHIFT) || (state_d == ST_WAIT) || (state_d == ST_CAPTURE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            phase_q <= 1'b0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rsh_q   <= '0;
            rdata_q <= '0;
            ss_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rsh_q   <= rsh_d;
            rdata_q <= rdata_d;
            ss_n_q  <= ss_n_d;
        end
    end

    spi_frame_shifter u_shifter (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .frame (frame),
        .sdo   (sh_sdo),
        .busy  (sh_busy),
        .last  (sh_last)
    );

    assign bus.ready = ready;
    assign bus.done  = (state_q == ST_DONE);
    assign bus.rdata = rdata_q;
    assign bus.ss_n  = ss_n_q;
    assign bus.mosi  = sh_sdo;

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: controller plus a behavioural single-clock SPI RAM slave.
// Table of host transactions with expected rdata/latency, then hand-written sequences for
// frame bit pattern, busy-time req, mid-frame reset and back-to-back requests.
module tb_spi_ram_master;

    localparam int MISO_DLY = 2;
    localparam int GAP_CYC  = 1;
    localparam int WR_LAT   = 23 + GAP_CYC;
    localparam int RD_LAT   = 31 + GAP_CYC + MISO_DLY;
    localparam int WR_HIT   = 12;
    localparam int RD_HIT   = 20 + MISO_DLY;

    logic clk = 1'b0;
    logic rst;

    spi_ram_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    spi_ram_master #(
        .ADDR_W   (8),
        .DATA_W   (8),
        .MISO_DLY (MISO_DLY),
        .GAP_CYC  (GAP_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural SPI RAM slave ----------------
    logic [7:0]  mem [256];
    logic [10:0] sh;
    int          bitn, post, bi;
    bit          rd_act;
    logic [7:0]  wa, ra;
    logic [10:0] frames [$];
    int          mosi_viol = 0;

    always @(negedge clk) begin
        if (bus.ss_n === 1'b1 && bus.mosi !== 1'b0) mosi_viol++;
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'h00;
            mem[8'h00] = 8'h3C;
            mem[8'h40] = 8'h96;
            bitn = 0; post = 0; rd_act = 0; wa = 0; ra = 0; sh = 0;
            bus.miso = 1'b0;
        end else if (bus.ss_n) begin
            bitn = 0; post = 0; rd_act = 0;
            bus.miso = 1'b0;
        end else if (rd_act) begin
            post++;
            if (post > MISO_DLY && post <= MISO_DLY + 8) begin
                bi = 7 - (post - MISO_DLY - 1);
                bus.miso = mem[ra][bi[2:0]];
            end else begin
                bus.miso = 1'b0;
            end
        end else begin
            sh = {sh[9:0], bus.mosi};
            bitn++;
            if (bitn == 11) begin
                frames.push_back(sh);
                bitn = 0;
                case (sh[10:8])
                    3'b000:  wa = sh[7:0];
                    3'b001:  mem[wa] = sh[7:0];
                    3'b110:  ra = sh[7:0];
                    3'b111:  begin rd_act = 1; post = 0; end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- host helpers ----------------
    task automatic run_txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                           output int lat, output logic [7:0] rd);
        @(negedge clk);
        bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
        @(negedge clk);
        bus.req = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        rd = bus.rdata;
        @(negedge clk);
        check("done_one_cycle", {31'd0, bus.done}, 32'd0);
    endtask

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        logic       hit;     // expected cache hit when the address cache is built in
    } vec_t;

    vec_t       vecs [10];
    int         lat, exp_lat, w, dn, base;
    logic [7:0] rd;
    logic       prev_ss;
    logic [10:0] f0, f1;

    initial begin
        rst = 1'b1;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = 8'h00; bus.wdata = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ss_n",  {31'd0, bus.ss_n},  32'd1);
        check("rst_mosi",  {31'd0, bus.mosi},  32'd0);
        check("rst_ready", {31'd0, bus.ready}, 32'd1);
        check("rst_done",  {31'd0, bus.done},  32'd0);
        check("rst_rdata", {24'd0, bus.rdata}, 32'h0);

        //           we    addr   wdata  exp_rd hit
        vecs[0] = '{1'b1, 8'h12, 8'hA5, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 8'h12, 8'h00, 8'hA5, 1'b0};
        vecs[2] = '{1'b0, 8'h12, 8'h00, 8'hA5, 1'b1};
        vecs[3] = '{1'b1, 8'h12, 8'h77, 8'h00, 1'b1};
        vecs[4] = '{1'b0, 8'h12, 8'h00, 8'h77, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 8'h00, 8'h3C, 1'b0};
        vecs[6] = '{1'b1, 8'hFF, 8'h5A, 8'h00, 1'b0};
        vecs[7] = '{1'b0, 8'hFF, 8'h00, 8'h5A, 1'b0};
        vecs[8] = '{1'b0, 8'h40, 8'h00, 8'h96, 1'b0};
        vecs[9] = '{1'b0, 8'h40, 8'h00, 8'h96, 1'b1};

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd);
`ifdef SPI_ADDR_CACHE_EN
            if (vecs[i].we) exp_lat = vecs[i].hit ? WR_HIT : WR_LAT;
            else            exp_lat = vecs[i].hit ? RD_HIT : RD_LAT;
`else
            exp_lat = vecs[i].we ? WR_LAT : RD_LAT;
`endif
            check($sformatf("vec%0d_latency", i), lat, exp_lat);
            if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), {24'd0, rd}, {24'd0, vecs[i].exp_rd});
        end

        // Frame bit pattern of a read of preloaded address 0.
        base = frames.size();
        run_txn(1'b0, 8'h00, 8'h00, lat, rd);
        check("rd00_latency", lat, RD_LAT);
        check("rd00_rdata", {24'd0, rd}, 32'h3C);
        check("rd00_frame_count", frames.size() - base, 2);
        f0 = (frames.size() > base)     ? frames[base]     : 11'h7FF;
        f1 = (frames.size() > base + 1) ? frames[base + 1] : 11'h7FF;
        check("rd00_frame1_bits", {21'd0, f0}, 32'h600);
        check("rd00_frame2_bits", {21'd0, f1}, 32'h700);

        // req held high through the busy period with changing inputs.
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 8'h33; bus.wdata = 8'h11;
        dn = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k <= 10) begin
                bus.addr  = 8'h33 + 8'(k);
                bus.wdata = 8'hF0 + 8'(k);
                bus.we    = k[0];
            end else begin
                bus.req = 1'b0;
            end
            if (bus.done === 1'b1) dn++;
        end
        check("busy_req_done_pulses", dn, 1);
        run_txn(1'b0, 8'h33, 8'h00, lat, rd);
        check("busy_req_rdata_33", {24'd0, rd}, 32'h11);
        run_txn(1'b0, 8'h34, 8'h00, lat, rd);
        check("busy_req_rdata_34", {24'd0, rd}, 32'h00);

        // Reset five cycles into the second frame of a write.
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 8'h50; bus.wdata = 8'hEE;
        @(negedge clk);
        bus.req = 1'b0;
        w = 0;
        while (bus.ss_n !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        while (bus.ss_n !== 1'b0 && w < 100) begin @(negedge clk); w++; end
        check("rst_seq_frame2_seen", {31'd0, (w < 100)}, 32'd1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ss_n",  {31'd0, bus.ss_n},  32'd1);
        check("midrst_ready", {31'd0, bus.ready}, 32'd1);
        check("midrst_done",  {31'd0, bus.done},  32'd0);
        check("midrst_mosi",  {31'd0, bus.mosi},  32'd0);
        rst = 1'b0;
        dn = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dn++;
        end
        check("midrst_no_done", dn, 0);
        check("midrst_rdata_cleared", {24'd0, bus.rdata}, 32'h0);
        run_txn(1'b1, 8'h50, 8'h99, lat, rd);
        check("postrst_wr_latency", lat, WR_LAT);
        run_txn(1'b0, 8'h50, 8'h00, lat, rd);
        check("postrst_rd_latency", lat, RD_LAT);
        check("postrst_rdata", {24'd0, rd}, 32'h99);

        // Back-to-back: read requested during the write's done cycle.
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 8'h60; bus.wdata = 8'hAB;
        @(negedge clk);
        bus.req = 1'b0;
        lat = 1;
        prev_ss = bus.ss_n;
        while (bus.done !== 1'b1 && lat < 200) begin
            prev_ss = bus.ss_n;
            @(negedge clk);
            lat++;
        end
        check("b2b_wr_latency", lat, WR_LAT);
        check("b2b_ss_low_before_done", {31'd0, prev_ss}, 32'd0);
        check("b2b_ss_high_in_done", {31'd0, bus.ss_n}, 32'd1);
        check("b2b_ready_in_done", {31'd0, bus.ready}, 32'd1);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 8'h60;
        @(negedge clk);
        bus.req = 1'b0;
        check("b2b_ss_low_next", {31'd0, bus.ss_n}, 32'd0);
        check("b2b_ready_low_next", {31'd0, bus.ready}, 32'd0);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
        check("b2b_rd_latency", lat, RD_LAT);
        check("b2b_rdata", {24'd0, bus.rdata}, 32'hAB);

        repeat (3) @(negedge clk);
        check("mosi_zero_while_ss_high", mosi_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
